inst_mem_loader: RTL and testbench
==================================

// Module: inst_mem_loader
// PURPOSE
//  Boot-time writer for the instruction memory. Receives a byte stream over a
//  valid/ready handshake and packs byte pairs into W-bit instruction words.
//  Writes words to consecutive instruction addresses starting at 0.
//  Holds the core off (CoreHold) until the programmed word count is loaded.
//  Sits between the host/testbench byte source and the write port of the
//  instruction RAM that the fetch stage reads.
// PARAMETERS
//  A  10  instruction address width; memory depth is 2**A words
//  W  9   instruction word width; legal range 9..16
// PORTS
//  Clk       in   1    system clock, rising edge
//  Reset     in   1    asynchronous, active-high reset
//  Start     in   1    one-cycle pulse; begins a load when idle
//  Length    in   A+1  word count to load, sampled on an accepted Start
//  InData    in   8    stream byte
//  InValid   in   1    InData is valid
//  InReady   out  1    loader accepts InData this cycle
//  WrEn      out  1    instruction memory write strobe
//  WrAddr    out  A    instruction memory write address
//  WrData    out  W    instruction memory write data
//  CoreHold  out  1    high while a load is in progress; core must stall
//  Done      out  1    one-cycle pulse when the load completes
// BEHAVIOUR
//  Clocking and reset
//  - Single clock domain.
//  - Reset is asynchronous and active-high.
//  - Reset values: InReady=0, WrEn=0, WrAddr=0, WrData=0, CoreHold=0, Done=0;
//    state=IDLE; word counter=0.
//  - Reset mid-load discards any partial word and the count. Memory contents
//    already written are not cleared.
//  States: IDLE, LO, HI, WRITE, FIN
//  - IDLE: Start=1 latches Len=min(Length, 2**A) and clears WrAddr to 0.
//    - Len==0: go to FIN directly.
//    - Otherwise: go to LO.
//    - CoreHold=1 from the cycle after Start.
//  - LO: InReady=1. On handshake (InValid&&InReady), capture InData as word
//    bits [7:0] and go to HI.
//  - HI: InReady=1. On handshake, capture InData[W-9:0] as word bits [W-1:8]
//    and go to WRITE. InData bits above W-9 are ignored.
//  - WRITE: InReady=0, WrEn=1 for exactly one cycle, WrData = packed word,
//    WrAddr = current address.
//    - Next cycle: WrAddr+1 and count+1.
//    - If count+1==Len, go to FIN; otherwise go to LO.
//  - FIN: Done=1 for one cycle, CoreHold=0 on the same edge, then go to IDLE.
//  Handshake and timing
//  - No handshake occurs when InValid=0; the state holds and stalls are
//    unbounded.
//  - InReady is registered; it never depends combinationally on InValid.
//  - Minimum cost is 3 cycles per word (LO, HI, WRITE).
//  - First WrEn occurs no earlier than 3 cycles after Start.
//  Boundaries
//  - Start outside IDLE is ignored; Length is not resampled.
//  - Len=2**A: the last write goes to address 2**A-1. WrAddr wraps to 0 after
//    that write; no write to address 0 follows.
//  - Length > 2**A is saturated to 2**A.
//  - WrEn is never asserted outside WRITE. WrAddr and WrData hold their last
//    values when not writing.
// TESTING
//  - Reset: assert Reset asynchronously mid-cycle -> all outputs 0
//    immediately, state IDLE.
//  - Basic load: Start, Length=3, bytes 0x01,0x00,0xFF,0x01,0x34,0x00
//    -> writes [0]=9'h001, [1]=9'h1FF, [2]=9'h034. Then one Done pulse,
//    CoreHold low.
//  - Backpressure: InValid toggled randomly with Length=4 -> the same 4 words
//    at addresses 0..3. One WrEn per word; no WrEn while bytes are missing.
//  - Zero/overflow: Length=0 -> Done two cycles after Start with no WrEn.
//    Length=2047 with A=10 -> exactly 1024 writes, last to address 1023.
//  - Start while busy: second Start during the load (Length=2, then 5)
//    -> only 2 words written.
//  - Reset mid-load: Reset after 1.5 words -> no further WrEn. A subsequent
//    load with Length=1 writes address 0.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory writer: packs byte pairs from a valid/ready
// stream into W-bit words and writes them to consecutive addresses from 0.
module inst_mem_loader #(
  parameter int unsigned A = 10,
  parameter int unsigned W = 9
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A:0]   Length,
  input  logic [7:0]   InData,
  input  logic         InValid,
  output logic         InReady,
  output logic         WrEn,
  output logic [A-1:0] WrAddr,
  output logic [W-1:0] WrData,
  output logic         CoreHold,
  output logic         Done
);

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WRITE,
    FIN
  } state_e;

  localparam logic [A:0] MAX_LEN = {1'b1, {A{1'b0}}};

  state_e         state_q, state_d;
  logic [A:0]     len_q, len_d;
  logic [A:0]     cnt_q, cnt_d;
  logic [7:0]     lo_q, lo_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [W-1:0]   data_q, data_d;
  logic           ready_q, ready_d;
  logic           wren_q, wren_d;
  logic           hold_q, hold_d;
  logic           done_q, done_d;

  logic           hs;
  logic [A:0]     len_sat;
  logic [A:0]     cnt_inc;
  logic           unused_indata;

  assign hs            = InValid && ready_q;
  assign len_sat       = (Length > MAX_LEN) ? MAX_LEN : Length;
  assign cnt_inc       = cnt_q + {{A{1'b0}}, 1'b1};
  // High InData bits beyond the word width are intentionally dropped.
  assign unused_indata = ^InData;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    data_d  = data_q;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          len_d   = len_sat;
          cnt_d   = '0;
          addr_d  = '0;
          state_d = (len_sat == '0) ? FIN : LO;
        end
      end
      LO: begin
        if (hs) begin
          lo_d    = InData;
          state_d = HI;
        end
      end
      HI: begin
        if (hs) begin
          data_d  = {InData[W-9:0], lo_q};
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + {{(A-1){1'b0}}, 1'b1};
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? FIN : LO;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with it.
    ready_d = (state_d == LO) || (state_d == HI);
    wren_d  = (state_d == WRITE);
    hold_d  = (state_d != IDLE);
    done_d  = (state_q == FIN);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      wren_q  <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      wren_q  <= wren_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  assign InReady  = ready_q;
  assign WrEn     = wren_q;
  assign WrAddr   = addr_q;
  assign WrData   = data_q;
  assign CoreHold = hold_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: loads, backpressure, zero/saturated
// lengths, ignored Start while busy and asynchronous reset mid-load.
module tb_inst_mem_loader;

  localparam int unsigned A = 10;
  localparam int unsigned W = 9;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic [A:0]   Length;
  logic [7:0]   InData;
  logic         InValid;
  logic         InReady;
  logic         WrEn;
  logic [A-1:0] WrAddr;
  logic [W-1:0] WrData;
  logic         CoreHold;
  logic         Done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem [1024];
  int           wr_cnt    = 0;
  int           done_cnt  = 0;
  logic [A-1:0] last_addr = '0;

  inst_mem_loader #(.A(A), .W(W)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Length  (Length),
    .InData  (InData),
    .InValid (InValid),
    .InReady (InReady),
    .WrEn    (WrEn),
    .WrAddr  (WrAddr),
    .WrData  (WrData),
    .CoreHold(CoreHold),
    .Done    (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (WrEn === 1'b1) begin
      mem[WrAddr] <= WrData;
      wr_cnt      <= wr_cnt + 1;
      last_addr   <= WrAddr;
    end
    if (Done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    InValid = 1'b0;
    repeat (gap) @(negedge Clk);
    InData  = b;
    InValid = 1'b1;
    for (int k = 0; k < 50 && InReady !== 1'b1; k++) @(negedge Clk);
    check("ready", InReady, 1);
    @(posedge Clk);
    @(negedge Clk);
    InValid = 1'b0;
  endtask

  task automatic pulse_start(input logic [A:0] len);
    Start  = 1'b1;
    Length = len;
    @(negedge Clk);
    Start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    for (int k = 0; k < bound && Done !== 1'b1; k++) @(negedge Clk);
    check(tag, Done, 1);
    check({tag, "_hold"}, CoreHold, 0);
  endtask

  int           base;
  int           dbase;
  int           bad;
  logic [9:0]   a;
  logic [7:0]   bp_bytes [8];
  int           bp_gaps  [8];

  initial begin
    Reset   = 1'b1;
    Start   = 1'b0;
    Length  = '0;
    InData  = '0;
    InValid = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_ready", InReady, 0);
    check("rst_wren",  WrEn, 0);
    check("rst_addr",  WrAddr, 0);
    check("rst_data",  WrData, 0);
    check("rst_hold",  CoreHold, 0);
    check("rst_done",  Done, 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Basic load of three words
    base  = wr_cnt;
    dbase = done_cnt;
    pulse_start(11'd3);
    check("b_hold1", CoreHold, 1);
    check("b_ready1", InReady, 1);
    check("b_wren1", WrEn, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    check("b_wren_w0", WrEn, 1);
    check("b_data_w0", WrData, 9'h001);
    check("b_addr_w0", WrAddr, 0);
    send_byte(8'hFF, 0); send_byte(8'h01, 0);
    send_byte(8'h34, 0); send_byte(8'h00, 0);
    wait_done("b_done", 20);
    @(negedge Clk);
    check("b_done_pulse", Done, 0);
    check("b_writes", wr_cnt - base, 3);
    check("b_ndone", done_cnt - dbase, 1);
    check("b_m0", mem[0], 9'h001);
    check("b_m1", mem[1], 9'h1FF);
    check("b_m2", mem[2], 9'h034);
    check("b_addr_hold", WrAddr, 3);
    check("b_data_hold", WrData, 9'h034);

    // Backpressure: gaps before bytes; upper byte bits above bit 0 ignored
    bp_bytes = '{8'h5A, 8'h01, 8'h00, 8'hFE, 8'hFF, 8'h03, 8'h80, 8'h00};
    bp_gaps  = '{2, 0, 1, 3, 0, 0, 2, 1};
    base = wr_cnt;
    pulse_start(11'd4);
    for (int i = 0; i < 8; i++) begin
      send_byte(bp_bytes[i], bp_gaps[i]);
      if (i % 2 == 0) check("bp_partial", wr_cnt - base, i / 2);
    end
    wait_done("bp_done", 20);
    check("bp_writes", wr_cnt - base, 4);
    check("bp_m0", mem[0], 9'h15A);
    check("bp_m1", mem[1], 9'h000);
    check("bp_m2", mem[2], 9'h1FF);
    check("bp_m3", mem[3], 9'h080);
    @(negedge Clk);

    // Zero length: Done two cycles after Start, no writes
    base = wr_cnt;
    pulse_start(11'd0);
    check("z_hold", CoreHold, 1);
    check("z_done_early", Done, 0);
    @(negedge Clk);
    check("z_done", Done, 1);
    check("z_hold_off", CoreHold, 0);
    check("z_writes", wr_cnt - base, 0);
    @(negedge Clk);

    // Overflow length saturates to 1024 words
    base = wr_cnt;
    pulse_start(11'd2047);
    for (int i = 0; i < 1024; i++) begin
      a = i[9:0];
      send_byte(a[7:0], 0);
      send_byte({7'h2A, a[8]}, 0);
    end
    wait_done("o_done", 20);
    check("o_writes", wr_cnt - base, 1024);
    check("o_last", last_addr, 1023);
    check("o_wrap", WrAddr, 0);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      a = i[9:0];
      if (mem[i] !== a[8:0]) bad++;
    end
    check("o_contents", bad, 0);
    InValid = 1'b1;
    repeat (5) @(negedge Clk);
    check("o_no_extra", wr_cnt - base, 1024);
    check("o_ready_idle", InReady, 0);
    InValid = 1'b0;

    // Start while busy is ignored
    base = wr_cnt;
    pulse_start(11'd2);
    send_byte(8'h11, 0); send_byte(8'h01, 0);
    pulse_start(11'd5);
    send_byte(8'h22, 0); send_byte(8'h00, 0);
    wait_done("sb_done", 20);
    InValid = 1'b1;
    repeat (4) @(negedge Clk);
    InValid = 1'b0;
    check("sb_writes", wr_cnt - base, 2);
    check("sb_m0", mem[0], 9'h111);
    check("sb_m1", mem[1], 9'h022);
    check("sb_ready", InReady, 0);

    // Asynchronous reset after 1.5 words
    pulse_start(11'd4);
    send_byte(8'h44, 0); send_byte(8'h00, 0); send_byte(8'h55, 0);
    #2 Reset = 1'b1;
    #1;
    check("ar_ready", InReady, 0);
    check("ar_wren", WrEn, 0);
    check("ar_addr", WrAddr, 0);
    check("ar_data", WrData, 0);
    check("ar_hold", CoreHold, 0);
    check("ar_done", Done, 0);
    @(negedge Clk);
    Reset = 1'b0;
    base = wr_cnt;
    InData  = 8'h01;
    InValid = 1'b1;
    repeat (6) @(negedge Clk);
    InValid = 1'b0;
    check("ar_no_write", wr_cnt - base, 0);
    pulse_start(11'd1);
    send_byte(8'h77, 0); send_byte(8'h01, 0);
    wait_done("ar2_done", 20);
    check("ar2_writes", wr_cnt - base, 1);
    check("ar2_addr", last_addr, 0);
    check("ar2_m0", mem[0], 9'h177);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
